// File: rtl/mk14_pkg.sv
// mk14_pkg: shared state type, key codes and ASCII-to-keypad map for the MK14 key injector
package mk14_pkg;

    typedef enum logic [2:0] {ki_IDLE, ki_PRESS, ki_HOLD, ki_RELEASE, ki_GAP} KI_STATE;

    typedef struct packed {
        logic       valid;
        logic [2:0] addr;
        logic [2:0] kbit;
    } key_t;

    localparam logic [7:0] KEY_0     = 8'h30;
    localparam logic [7:0] KEY_8     = 8'h38;
    localparam logic [7:0] KEY_9     = 8'h39;
    localparam logic [7:0] KEY_A     = 8'h41;
    localparam logic [7:0] KEY_D     = 8'h44;
    localparam logic [7:0] KEY_E     = 8'h45;
    localparam logic [7:0] KEY_F     = 8'h46;
    localparam logic [7:0] KEY_GO    = 8'h47;
    localparam logic [7:0] KEY_MEM   = 8'h4D;
    localparam logic [7:0] KEY_TERM  = 8'h54;
    localparam logic [7:0] KEY_ABORT = 8'h5A;
    localparam logic [7:0] LOWER_A   = 8'h61;
    localparam logic [7:0] LOWER_F   = 8'h66;

    function automatic key_t key_map(input logic [7:0] code);
        logic [7:0] c;
        c = (code >= LOWER_A && code <= LOWER_F) ? code - 8'h20 : code;
        if (c >= KEY_0 && c < KEY_8) return '{1'b1, c[2:0], 3'd7};
        if (c >= KEY_A && c <= KEY_D) return '{1'b1, c[2:0] - 3'd1, 3'd4};
        case (c)
            KEY_8:     return '{1'b1, 3'd0, 3'd6};
            KEY_9:     return '{1'b1, 3'd1, 3'd6};
            KEY_E:     return '{1'b1, 3'd6, 3'd4};
            KEY_F:     return '{1'b1, 3'd7, 3'd4};
            KEY_GO:    return '{1'b1, 3'd2, 3'd5};
            KEY_MEM:   return '{1'b1, 3'd3, 3'd5};
            KEY_ABORT: return '{1'b1, 3'd4, 3'd5};
            KEY_TERM:  return '{1'b1, 3'd7, 3'd5};
            default:   return '0;
        endcase
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: registered FIFO with wrap-bit pointers; push ignored when full, pop ignored when empty
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign empty   = wr_ptr == rd_ptr;
    assign full    = wr_ptr == {~rd_ptr[AW], rd_ptr[AW-1:0]};
    assign rdata   = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk)
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            wr_ptr <= wr_ptr + (AW+1)'(do_push);
            rd_ptr <= rd_ptr + (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/mk14_key_injector.sv
// mk14_key_injector: buffers ASCII key codes and replays them as timed MK14 keypad press/release strobes
module mk14_key_injector
    import mk14_pkg::*;
#(
    parameter int HOLD_CYCLES = 2_500_000,
    parameter int GAP_CYCLES  = 1_000_000,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_en,
    input  logic [7:0] i_code,
    input  logic       i_valid,
    output logic       o_ready,
    output logic       o_kbd_write_en,
    output logic [2:0] o_kbd_addr,
    output logic [2:0] o_kbd_bit,
    output logic       o_kbd_pressed,
    output logic       o_idle,
    output logic       o_drop
);
    localparam int CW = $clog2((HOLD_CYCLES > GAP_CYCLES ? HOLD_CYCLES : GAP_CYCLES) + 1);

    KI_STATE       state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [7:0]    head;
    logic          empty, full, pop;
    key_t          km;
    logic [2:0]    key_addr, key_bit, key_addr_nx, key_bit_nx, addr_nx, bit_nx;
    logic          write_en_nx, pressed_nx, drop_nx;

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (i_valid),
        .wdata (i_code),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    assign km      = key_map(head);
    assign o_ready = !full;
    assign o_idle  = empty && state == ki_IDLE;

    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        pop         = 1'b0;
        key_addr_nx = key_addr;
        key_bit_nx  = key_bit;
        addr_nx     = o_kbd_addr;
        bit_nx      = o_kbd_bit;
        write_en_nx = 1'b0;
        pressed_nx  = o_kbd_pressed;
        drop_nx     = 1'b0;
        case (state)
            ki_IDLE: if (i_en && !empty) begin
                pop = 1'b1;
                if (km.valid) begin
                    key_addr_nx = km.addr;
                    key_bit_nx  = km.kbit;
                    state_nx    = ki_PRESS;
                end else begin
                    drop_nx = 1'b1;
                end
            end
            ki_PRESS: begin
                write_en_nx = 1'b1;
                pressed_nx  = 1'b1;
                addr_nx     = key_addr;
                bit_nx      = key_bit;
                cnt_nx      = CW'(HOLD_CYCLES - 1);
                state_nx    = ki_HOLD;
            end
            ki_HOLD: if (cnt == '0) state_nx = ki_RELEASE; else cnt_nx = cnt - CW'(1);
            ki_RELEASE: begin
                write_en_nx = 1'b1;
                pressed_nx  = 1'b0;
                addr_nx     = key_addr;
                bit_nx      = key_bit;
                cnt_nx      = CW'(GAP_CYCLES - 1);
                state_nx    = ki_GAP;
            end
            ki_GAP: if (cnt == '0) state_nx = ki_IDLE; else cnt_nx = cnt - CW'(1);
            default: state_nx = ki_IDLE;
        endcase
    end

    // Strobe outputs are registered from the PRESS/RELEASE states, one cycle behind the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ki_IDLE;
            cnt            <= '0;
            key_addr       <= '0;
            key_bit        <= '0;
            o_kbd_write_en <= 1'b0;
            o_kbd_addr     <= '0;
            o_kbd_bit      <= '0;
            o_kbd_pressed  <= 1'b0;
            o_drop         <= 1'b0;
        end else begin
            state          <= state_nx;
            cnt            <= cnt_nx;
            key_addr       <= key_addr_nx;
            key_bit        <= key_bit_nx;
            o_kbd_write_en <= write_en_nx;
            o_kbd_addr     <= addr_nx;
            o_kbd_bit      <= bit_nx;
            o_kbd_pressed  <= pressed_nx;
            o_drop         <= drop_nx;
        end
    end

endmodule

// File: tb/tb_mk14_key_injector.sv
// tb_mk14_key_injector: randomized and directed checks against a queue-based timing model of the key injector
module tb_mk14_key_injector;
    localparam int H = 4;
    localparam int G = 2;
    localparam int D = 4;

    typedef struct packed {
        int         t;
        logic [1:0] k;
        logic [2:0] a;
        logic [2:0] b;
    } ev_t;

    logic       clk = 1'b0, rst_n = 1'b0, i_en = 1'b0, i_valid = 1'b0;
    logic [7:0] i_code = 8'h00;
    logic       o_ready, o_kbd_write_en, o_kbd_pressed, o_idle, o_drop;
    logic [2:0] o_kbd_addr, o_kbd_bit;

    int         cyc = 0, free_at = 0, vectors = 0, miscompares = 0;
    logic [7:0] mq[$];
    ev_t        exp_ev[$], act_ev[$];

    mk14_key_injector #(.HOLD_CYCLES(H), .GAP_CYCLES(G), .FIFO_DEPTH(D)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_en           (i_en),
        .i_code         (i_code),
        .i_valid        (i_valid),
        .o_ready        (o_ready),
        .o_kbd_write_en (o_kbd_write_en),
        .o_kbd_addr     (o_kbd_addr),
        .o_kbd_bit      (o_kbd_bit),
        .o_kbd_pressed  (o_kbd_pressed),
        .o_idle         (o_idle),
        .o_drop         (o_drop)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference key table: returns {valid, addr, bit}
    function automatic logic [6:0] ref_map(input logic [7:0] code);
        string      keys = "0123456789ABCDEFGMZT";
        int         ad[20] = '{0,1,2,3,4,5,6,7,0,1,0,1,2,3,6,7,2,3,4,7};
        int         bt[20] = '{7,7,7,7,7,7,7,7,6,6,4,4,4,4,4,4,5,5,5,5};
        logic [7:0] c;
        c = (code >= 8'h61 && code <= 8'h66) ? code - 8'h20 : code;
        for (int i = 0; i < 20; i++)
            if (keys[i] == c) return {1'b1, 3'(ad[i]), 3'(bt[i])};
        return '0;
    endfunction

    // Model: a pop at edge t yields press at t+1, release at t+H+2, next pop no earlier than t+H+G+3
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            free_at = 0;
            while (exp_ev.size() > 0 && exp_ev[exp_ev.size()-1].t > cyc) void'(exp_ev.pop_back());
        end else begin
            int         t;
            logic [6:0] m;
            logic       acc;
            t   = cyc + 1;
            acc = i_valid && mq.size() < D;
            if (t >= free_at && i_en && mq.size() > 0) begin
                m = ref_map(mq.pop_front());
                if (m[6]) begin
                    exp_ev.push_back('{t + 1, 2'd1, m[5:3], m[2:0]});
                    exp_ev.push_back('{t + H + 2, 2'd0, m[5:3], m[2:0]});
                    free_at = t + H + G + 3;
                end else begin
                    exp_ev.push_back('{t, 2'd2, 3'd0, 3'd0});
                    free_at = t + 1;
                end
            end
            if (acc) mq.push_back(i_code);
        end
    end

    always @(negedge clk) if (rst_n) begin
        if (o_kbd_write_en) act_ev.push_back('{cyc, {1'b0, o_kbd_pressed}, o_kbd_addr, o_kbd_bit});
        if (o_drop) act_ev.push_back('{cyc, 2'd2, 3'd0, 3'd0});
    end

    task automatic push(input logic [7:0] c);
        i_valid = 1'b1;
        i_code  = c;
        @(negedge clk);
        i_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (!(mq.size() == 0 && cyc >= free_at && o_idle === 1'b1) && n < 500) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (n >= 500) begin
            miscompares++;
            $display("FAIL drain_timeout o_idle=%b model_queue=%0d", o_idle, mq.size());
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        for (int r = 0; r < 2; r++) begin
            vectors += 7;
            if (o_kbd_write_en !== 1'b0) begin miscompares++; $display("FAIL reset_we got %b want 0", o_kbd_write_en); end
            if (o_kbd_addr !== 3'd0) begin miscompares++; $display("FAIL reset_addr got %0d want 0", o_kbd_addr); end
            if (o_kbd_bit !== 3'd0) begin miscompares++; $display("FAIL reset_bit got %0d want 0", o_kbd_bit); end
            if (o_kbd_pressed !== 1'b0) begin miscompares++; $display("FAIL reset_pressed got %b want 0", o_kbd_pressed); end
            if (o_drop !== 1'b0) begin miscompares++; $display("FAIL reset_drop got %b want 0", o_drop); end
            if (o_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready got %b want 1", o_ready); end
            if (o_idle !== 1'b1) begin miscompares++; $display("FAIL reset_idle got %b want 1", o_idle); end
            rst_n = 1'b1;
            @(negedge clk);
        end
    endtask

    task automatic test_single_key();
        exp_ev.delete(); act_ev.delete();
        i_en = 1'b1;
        push("5");
        for (int c = 0; c < 14; c++) begin
            vectors++;
            if (o_idle !== (mq.size() == 0 && cyc >= free_at - 1)) begin
                miscompares++;
                $display("FAIL single_idle cycle %0d got %b want %b", cyc, o_idle, mq.size() == 0 && cyc >= free_at - 1);
            end
            @(negedge clk);
        end
        drain();
        for (int i = 0; i < exp_ev.size() || i < act_ev.size(); i++) begin
            vectors++;
            if (i >= exp_ev.size() || i >= act_ev.size() || act_ev[i] !== exp_ev[i]) begin
                miscompares++;
                $display("FAIL single_ev[%0d] got %p want %p (sizes %0d/%0d)", i, act_ev[i], exp_ev[i], act_ev.size(), exp_ev.size());
            end
        end
    endtask

    task automatic test_burst();
        exp_ev.delete(); act_ev.delete();
        i_en = 1'b1;
        push("3"); push("A"); push("G");
        drain();
        for (int i = 0; i < exp_ev.size() || i < act_ev.size(); i++) begin
            vectors++;
            if (i >= exp_ev.size() || i >= act_ev.size() || act_ev[i] !== exp_ev[i]) begin
                miscompares++;
                $display("FAIL burst_ev[%0d] got %p want %p (sizes %0d/%0d)", i, act_ev[i], exp_ev[i], act_ev.size(), exp_ev.size());
            end
        end
    endtask

    task automatic test_overflow();
        string codes = "1234E7";
        exp_ev.delete(); act_ev.delete();
        i_en = 1'b0;
        for (int k = 0; k < 6; k++) begin
            push(codes[k]);
            vectors++;
            if (o_ready !== (mq.size() < D)) begin
                miscompares++;
                $display("FAIL overflow_ready after push %0d got %b want %b", k, o_ready, mq.size() < D);
            end
        end
        repeat (3) @(negedge clk);
        i_en = 1'b1;
        drain();
        for (int i = 0; i < exp_ev.size() || i < act_ev.size(); i++) begin
            vectors++;
            if (i >= exp_ev.size() || i >= act_ev.size() || act_ev[i] !== exp_ev[i]) begin
                miscompares++;
                $display("FAIL overflow_ev[%0d] got %p want %p (sizes %0d/%0d)", i, act_ev[i], exp_ev[i], act_ev.size(), exp_ev.size());
            end
        end
    endtask

    task automatic test_unmapped();
        exp_ev.delete(); act_ev.delete();
        i_en = 1'b1;
        push("x"); push("9");
        drain();
        for (int i = 0; i < exp_ev.size() || i < act_ev.size(); i++) begin
            vectors++;
            if (i >= exp_ev.size() || i >= act_ev.size() || act_ev[i] !== exp_ev[i]) begin
                miscompares++;
                $display("FAIL unmapped_ev[%0d] got %p want %p (sizes %0d/%0d)", i, act_ev[i], exp_ev[i], act_ev.size(), exp_ev.size());
            end
        end
    endtask

    task automatic test_enable_mid_key();
        exp_ev.delete(); act_ev.delete();
        i_en = 1'b1;
        push("M"); push("1");
        for (int n = 0; n < 50 && act_ev.size() == 0; n++) @(negedge clk);
        i_en = 1'b0;
        repeat (20) @(negedge clk);
        vectors++;
        if (o_idle !== 1'b0 || act_ev.size() != exp_ev.size()) begin
            miscompares++;
            $display("FAIL enmid_hold o_idle=%b want 0, events %0d want %0d", o_idle, act_ev.size(), exp_ev.size());
        end
        i_en = 1'b1;
        drain();
        for (int i = 0; i < exp_ev.size() || i < act_ev.size(); i++) begin
            vectors++;
            if (i >= exp_ev.size() || i >= act_ev.size() || act_ev[i] !== exp_ev[i]) begin
                miscompares++;
                $display("FAIL enmid_ev[%0d] got %p want %p (sizes %0d/%0d)", i, act_ev[i], exp_ev[i], act_ev.size(), exp_ev.size());
            end
        end
    endtask

    task automatic test_reset_mid_key();
        exp_ev.delete(); act_ev.delete();
        i_en = 1'b1;
        push("D"); push("E");
        for (int n = 0; n < 50 && act_ev.size() == 0; n++) @(negedge clk);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        vectors += 6;
        if (o_kbd_addr !== 3'd0) begin miscompares++; $display("FAIL rstmid_addr got %0d want 0", o_kbd_addr); end
        if (o_kbd_bit !== 3'd0) begin miscompares++; $display("FAIL rstmid_bit got %0d want 0", o_kbd_bit); end
        if (o_kbd_pressed !== 1'b0) begin miscompares++; $display("FAIL rstmid_pressed got %b want 0", o_kbd_pressed); end
        if (o_kbd_write_en !== 1'b0) begin miscompares++; $display("FAIL rstmid_we got %b want 0", o_kbd_write_en); end
        if (o_ready !== 1'b1) begin miscompares++; $display("FAIL rstmid_ready got %b want 1", o_ready); end
        if (o_idle !== 1'b1) begin miscompares++; $display("FAIL rstmid_idle got %b want 1", o_idle); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        vectors++;
        if (o_idle !== 1'b1) begin miscompares++; $display("FAIL rstmid_after_idle got %b want 1", o_idle); end
        for (int i = 0; i < exp_ev.size() || i < act_ev.size(); i++) begin
            vectors++;
            if (i >= exp_ev.size() || i >= act_ev.size() || act_ev[i] !== exp_ev[i]) begin
                miscompares++;
                $display("FAIL rstmid_ev[%0d] got %p want %p (sizes %0d/%0d)", i, act_ev[i], exp_ev[i], act_ev.size(), exp_ev.size());
            end
        end
    endtask

    task automatic test_random();
        string pool = "0123456789ABCDEFGMZTabcdefxq!";
        exp_ev.delete(); act_ev.delete();
        for (int c = 0; c < 400; c++) begin
            i_valid = $urandom_range(0, 2) == 0;
            i_code  = pool[$urandom_range(0, pool.len() - 1)];
            i_en    = $urandom_range(0, 9) != 0;
            @(negedge clk);
            vectors++;
            if (o_ready !== (mq.size() < D)) begin
                miscompares++;
                $display("FAIL random_ready cycle %0d got %b want %b", cyc, o_ready, mq.size() < D);
            end
        end
        i_valid = 1'b0;
        i_en    = 1'b1;
        drain();
        for (int i = 0; i < exp_ev.size() || i < act_ev.size(); i++) begin
            vectors++;
            if (i >= exp_ev.size() || i >= act_ev.size() || act_ev[i] !== exp_ev[i]) begin
                miscompares++;
                $display("FAIL random_ev[%0d] got %p want %p (sizes %0d/%0d)", i, act_ev[i], exp_ev[i], act_ev.size(), exp_ev.size());
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_key();
        test_burst();
        test_overflow();
        test_unmapped();
        test_enable_mid_key();
        test_random();
        test_reset_mid_key();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
